// File: rtl/baser_257b_pkg.sv
// Shared constants, state/phase encodings and block builders
// for the 256b/257b traffic sequencer.
package baser_257b_pkg;

    localparam int DATA_WIDTH    = 64;
    localparam int TC_DATA_WIDTH = 4 * DATA_WIDTH;
    localparam int SH_WIDTH      = 1;
    localparam int TC_WIDTH      = TC_DATA_WIDTH + SH_WIDTH;

    localparam logic [7:0] DATA_CHAR_PATTERN = 8'hAA;
    localparam logic [7:0] CTRL_CHAR_PATTERN = 8'h55;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_CTRL,
        S_INV,
        S_DRAIN,
        S_CHECK
    } seq_state_t;

    localparam logic [1:0] PH_DATA = 2'd0;
    localparam logic [1:0] PH_CTRL = 2'd1;
    localparam logic [1:0] PH_INV  = 2'd2;
    localparam logic [1:0] PH_NONE = 2'd3;

    function automatic logic [TC_WIDTH-1:0] mk_data_block(
        input logic [7:0] dp
    );
        return {{32{dp}}, 1'b1};
    endfunction

    // Block-type nibble 4'b1110 marks a control block
    function automatic logic [TC_WIDTH-1:0] mk_ctrl_block(
        input logic [7:0] dp,
        input logic [7:0] cp
    );
        logic [63:0] c;
        c = {8{cp}};
        return {{24{dp}}, c[59:0], 4'b1110, 1'b0};
    endfunction

    function automatic logic [TC_WIDTH-1:0] mk_inv_block(
        input logic [7:0] dp
    );
        logic [255:0] d;
        d = {32{dp}};
        return {d[251:0], 4'b1111, 1'b0};
    endfunction

endpackage

// File: rtl/baser_257b_traffic_sequencer_count_compare.sv
// Captures checker counter baselines at start and checks the
// modular deltas against the programmed block counts.
module baser_257b_count_compare (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_capture,
    input  logic [31:0] i_cur_block,
    input  logic [31:0] i_cur_data,
    input  logic [31:0] i_cur_ctrl,
    input  logic [31:0] i_cur_inv,
    input  logic [31:0] i_exp_block,
    input  logic [31:0] i_exp_data,
    input  logic [31:0] i_exp_ctrl,
    input  logic [31:0] i_exp_inv,
    output logic        o_match
);

    logic [31:0] r_base_block;
    logic [31:0] r_base_data;
    logic [31:0] r_base_ctrl;
    logic [31:0] r_base_inv;

    logic [31:0] w_d_block;
    logic [31:0] w_d_data;
    logic [31:0] w_d_ctrl;
    logic [31:0] w_d_inv;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base_block <= '0;
            r_base_data  <= '0;
            r_base_ctrl  <= '0;
            r_base_inv   <= '0;
        end else if (i_capture) begin
            r_base_block <= i_cur_block;
            r_base_data  <= i_cur_data;
            r_base_ctrl  <= i_cur_ctrl;
            r_base_inv   <= i_cur_inv;
        end
    end

    // 32-bit subtraction wraps, so counter rollover mid-run is harmless
    assign w_d_block = i_cur_block - r_base_block;
    assign w_d_data  = i_cur_data  - r_base_data;
    assign w_d_ctrl  = i_cur_ctrl  - r_base_ctrl;
    assign w_d_inv   = i_cur_inv   - r_base_inv;

    assign o_match = (w_d_block == i_exp_block) &&
                     (w_d_data  == i_exp_data)  &&
                     (w_d_ctrl  == i_exp_ctrl)  &&
                     (w_d_inv   == i_exp_inv);

endmodule

// File: rtl/baser_257b_traffic_sequencer.sv
// Emits a data/ctrl/invalid burst of 257b transcoded blocks and
// verifies the downstream checker counted each class correctly.
module baser_257b_traffic_sequencer
    import baser_257b_pkg::*;
#(
    parameter logic [7:0] P_DATA_CHAR = DATA_CHAR_PATTERN,
    parameter logic [7:0] P_CTRL_CHAR = CTRL_CHAR_PATTERN,
    parameter int         CNT_WIDTH   = 16,
    parameter int         CHK_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [CNT_WIDTH-1:0] i_n_data,
    input  logic [CNT_WIDTH-1:0] i_n_ctrl,
    input  logic [CNT_WIDTH-1:0] i_n_inv,
    input  logic                 i_ready,
    input  logic [31:0]          i_chk_block_count,
    input  logic [31:0]          i_chk_data_count,
    input  logic [31:0]          i_chk_ctrl_count,
    input  logic [31:0]          i_chk_inv_count,
    output logic [TC_WIDTH-1:0]  o_tx_coded,
    output logic                 o_valid,
    output logic                 o_busy,
    output logic [1:0]           o_phase,
    output logic                 o_done,
    output logic                 o_pass,
    output logic                 o_fail
);

    seq_state_t r_state;
    seq_state_t w_state_nx;

    logic [CNT_WIDTH-1:0] r_n_data;
    logic [CNT_WIDTH-1:0] r_n_ctrl;
    logic [CNT_WIDTH-1:0] r_n_inv;
    logic [CNT_WIDTH-1:0] r_rem_data;
    logic [CNT_WIDTH-1:0] r_rem_ctrl;
    logic [CNT_WIDTH-1:0] r_rem_inv;
    logic [7:0]           r_drain_cnt;
    logic                 r_pass;
    logic                 r_fail;

    logic                 w_start;
    logic                 w_xfer;
    logic                 w_match;
    logic [CNT_WIDTH+1:0] w_sum;

    assign w_start = (r_state == S_IDLE) && i_start;
    assign w_xfer  = o_valid && i_ready;
    assign w_sum   = (CNT_WIDTH+2)'(r_n_data)
                   + (CNT_WIDTH+2)'(r_n_ctrl)
                   + (CNT_WIDTH+2)'(r_n_inv);

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_n_data != '0)      w_state_nx = S_DATA;
                    else if (i_n_ctrl != '0) w_state_nx = S_CTRL;
                    else if (i_n_inv != '0)  w_state_nx = S_INV;
                    else                     w_state_nx = S_DRAIN;
                end
            end
            S_DATA: begin
                if (w_xfer && r_rem_data == CNT_WIDTH'(1)) begin
                    if (r_n_ctrl != '0)     w_state_nx = S_CTRL;
                    else if (r_n_inv != '0) w_state_nx = S_INV;
                    else                    w_state_nx = S_DRAIN;
                end
            end
            S_CTRL: begin
                if (w_xfer && r_rem_ctrl == CNT_WIDTH'(1)) begin
                    if (r_n_inv != '0) w_state_nx = S_INV;
                    else               w_state_nx = S_DRAIN;
                end
            end
            S_INV: begin
                if (w_xfer && r_rem_inv == CNT_WIDTH'(1))
                    w_state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_drain_cnt == 8'(CHK_LATENCY - 1))
                    w_state_nx = S_CHECK;
            end
            S_CHECK: w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_n_data   <= '0;
            r_n_ctrl   <= '0;
            r_n_inv    <= '0;
            r_rem_data <= '0;
            r_rem_ctrl <= '0;
            r_rem_inv  <= '0;
        end else if (w_start) begin
            r_n_data   <= i_n_data;
            r_n_ctrl   <= i_n_ctrl;
            r_n_inv    <= i_n_inv;
            r_rem_data <= i_n_data;
            r_rem_ctrl <= i_n_ctrl;
            r_rem_inv  <= i_n_inv;
        end else if (w_xfer) begin
            if (r_state == S_DATA) r_rem_data <= r_rem_data - 1'b1;
            if (r_state == S_CTRL) r_rem_ctrl <= r_rem_ctrl - 1'b1;
            if (r_state == S_INV)  r_rem_inv  <= r_rem_inv - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drain_cnt <= '0;
        end else if (r_state == S_DRAIN) begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
        end else begin
            r_drain_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (w_start) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (r_state == S_CHECK) begin
            r_pass <= w_match;
            r_fail <= !w_match;
        end
    end

    baser_257b_count_compare u_cmp (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_capture   (w_start),
        .i_cur_block (i_chk_block_count),
        .i_cur_data  (i_chk_data_count),
        .i_cur_ctrl  (i_chk_ctrl_count),
        .i_cur_inv   (i_chk_inv_count),
        .i_exp_block (32'(w_sum)),
        .i_exp_data  (32'(r_n_data)),
        .i_exp_ctrl  (32'(r_n_ctrl)),
        .i_exp_inv   (32'(r_n_inv)),
        .o_match     (w_match)
    );

    always_comb begin
        o_tx_coded = mk_data_block(P_DATA_CHAR);
        o_phase    = PH_NONE;
        unique case (r_state)
            S_DATA: begin
                o_phase = PH_DATA;
            end
            S_CTRL: begin
                o_tx_coded = mk_ctrl_block(P_DATA_CHAR, P_CTRL_CHAR);
                o_phase    = PH_CTRL;
            end
            S_INV: begin
                o_tx_coded = mk_inv_block(P_DATA_CHAR);
                o_phase    = PH_INV;
            end
            default: begin
                o_phase = PH_NONE;
            end
        endcase
    end

    assign o_valid = (r_state == S_DATA) || (r_state == S_CTRL) ||
                     (r_state == S_INV);
    assign o_busy  = (r_state != S_IDLE);
    assign o_done  = (r_state == S_CHECK);
    // Result is visible during the CHECK cycle, then held in registers
    assign o_pass  = (r_state == S_CHECK) ? w_match  : r_pass;
    assign o_fail  = (r_state == S_CHECK) ? !w_match : r_fail;

endmodule

// File: tb/tb_baser_257b_traffic_sequencer.sv
// Directed bench for the 257b traffic sequencer with a behavioural
// checker model that counts accepted blocks two cycles late.
module tb_baser_257b_traffic_sequencer;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [15:0]  n_data;
    logic [15:0]  n_ctrl;
    logic [15:0]  n_inv;
    logic         ready;
    logic [31:0]  c_blk;
    logic [31:0]  c_dat;
    logic [31:0]  c_ctl;
    logic [31:0]  c_inv;
    logic [256:0] tx;
    logic         valid;
    logic         busy;
    logic [1:0]   phase;
    logic         done;
    logic         pass;
    logic         fail;

    int n_chk;
    int n_fail;
    int done_k;
    int first_v;
    int stall_err;

    logic         mis_mode;
    logic         preset_en;
    logic [31:0]  preset_val;

    logic         p_v;
    logic [1:0]   p_t;
    int           ntx;
    int           ctrl_seen;
    logic [1:0]   seq [0:31];
    logic [256:0] blk [0:31];

    logic [256:0] exp_d;
    logic [256:0] exp_c;
    logic [256:0] exp_i;
    logic [1:0]   typ;
    logic [1:0]   eff;

    baser_257b_traffic_sequencer dut (
        .clk               (clk),
        .i_rst_n           (rst_n),
        .i_start           (start),
        .i_n_data          (n_data),
        .i_n_ctrl          (n_ctrl),
        .i_n_inv           (n_inv),
        .i_ready           (ready),
        .i_chk_block_count (c_blk),
        .i_chk_data_count  (c_dat),
        .i_chk_ctrl_count  (c_ctl),
        .i_chk_inv_count   (c_inv),
        .o_tx_coded        (tx),
        .o_valid           (valid),
        .o_busy            (busy),
        .o_phase           (phase),
        .o_done            (done),
        .o_pass            (pass),
        .o_fail            (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        typ = 2'd3;
        if (tx[0])                  typ = 2'd0;
        else if (tx[4:1] == 4'hE)   typ = 2'd1;
        else if (tx[4:1] == 4'hF)   typ = 2'd2;
        eff = typ;
        if (mis_mode && typ == 2'd1 && ctrl_seen == 0) eff = 2'd0;
    end

    // Checker model: classify at accept, update counters one edge later
    always @(posedge clk) begin
        if (preset_en) begin
            c_blk <= preset_val;
            c_dat <= preset_val - 32'd1;
            c_ctl <= preset_val - 32'd2;
            c_inv <= preset_val - 32'd3;
        end else if (p_v) begin
            c_blk <= c_blk + 32'd1;
            if (p_t == 2'd0) c_dat <= c_dat + 32'd1;
            if (p_t == 2'd1) c_ctl <= c_ctl + 32'd1;
            if (p_t == 2'd2) c_inv <= c_inv + 32'd1;
        end
        p_v <= valid && ready;
        p_t <= eff;
        if (start && !busy) begin
            ntx       <= 0;
            ctrl_seen <= 0;
        end else if (valid && ready) begin
            if (ntx < 32) begin
                seq[ntx] <= typ;
                blk[ntx] <= tx;
            end
            ntx <= ntx + 1;
            if (typ == 2'd1) ctrl_seen <= ctrl_seen + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [256:0] obs,
                            input logic [256:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_seq(input logic [15:0] nd, input logic [15:0] nc,
                           input logic [15:0] ni, input int rmode);
        logic         stalled;
        logic [256:0] ptx;
        logic [1:0]   pph;
        done_k    = 0;
        first_v   = 0;
        stall_err = 0;
        n_data    = nd;
        n_ctrl    = nc;
        n_inv     = ni;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (valid && first_v == 0) first_v = k;
            if (done) begin
                done_k = k;
                break;
            end
            ready   = (rmode == 0) ? 1'b1 : (k % 3 == 1);
            stalled = valid && !ready;
            ptx     = tx;
            pph     = phase;
            @(posedge clk);
            #1;
            if (stalled && (tx !== ptx || phase !== pph))
                stall_err++;
        end
        ready = 1'b1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        n_data     = '0;
        n_ctrl     = '0;
        n_inv      = '0;
        ready      = 1'b1;
        mis_mode   = 1'b0;
        preset_en  = 1'b0;
        preset_val = '0;
        c_blk      = '0;
        c_dat      = '0;
        c_ctl      = '0;
        c_inv      = '0;
        p_v        = 1'b0;
        p_t        = '0;
        ntx        = 0;
        ctrl_seen  = 0;
        exp_d = {{32{8'hAA}}, 1'b1};
        exp_c = {{24{8'hAA}}, {15{4'h5}}, 4'b1110, 1'b0};
        exp_i = {{31{8'hAA}}, 4'hA, 4'b1111, 1'b0};

        #12;
        check_eq("rst_valid", valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass, 0);
        check_eq("rst_fail", fail, 0);
        check_eq("rst_phase", phase, 3);
        check_eq("rst_tx", tx, exp_d);
        rst_n = 1'b1;
        step(2);

        // 3/2/1 with ready held high
        run_seq(16'd3, 16'd2, 16'd1, 0);
        check_eq("t1_first_valid", first_v, 1);
        check_eq("t1_done_cycle", done_k, 9);
        check_eq("t1_ntx", ntx, 6);
        check_eq("t1_seq0", seq[0], 0);
        check_eq("t1_seq1", seq[1], 0);
        check_eq("t1_seq2", seq[2], 0);
        check_eq("t1_seq3", seq[3], 1);
        check_eq("t1_seq4", seq[4], 1);
        check_eq("t1_seq5", seq[5], 2);
        check_eq("t1_blk_data", blk[0], exp_d);
        check_eq("t1_blk_ctrl", blk[3], exp_c);
        check_eq("t1_blk_inv", blk[5], exp_i);
        check_eq("t1_pass", pass, 1);
        check_eq("t1_fail", fail, 0);
        step(1);
        check_eq("t1_busy_after", busy, 0);
        check_eq("t1_pass_held", pass, 1);

        // Empty run goes straight to drain
        run_seq(16'd0, 16'd0, 16'd0, 0);
        check_eq("t2_first_valid", first_v, 0);
        check_eq("t2_done_cycle", done_k, 3);
        check_eq("t2_ntx", ntx, 0);
        check_eq("t2_pass", pass, 1);
        step(1);

        // Backpressure pattern
        run_seq(16'd4, 16'd0, 16'd0, 1);
        check_eq("t3_done_seen", done_k != 0, 1);
        check_eq("t3_stall_stable", stall_err, 0);
        check_eq("t3_ntx", ntx, 4);
        check_eq("t3_pass", pass, 1);
        step(1);

        // Checker miscounts one ctrl block as data
        mis_mode = 1'b1;
        run_seq(16'd2, 16'd2, 16'd0, 0);
        check_eq("t4_done_cycle", done_k, 7);
        check_eq("t4_fail", fail, 1);
        check_eq("t4_pass", pass, 0);
        mis_mode = 1'b0;
        step(2);
        check_eq("t4_fail_held", fail, 1);

        // Baselines near the 32-bit wrap point
        preset_val = 32'hFFFF_FFFE;
        preset_en  = 1'b1;
        step(1);
        preset_en = 1'b0;
        step(1);
        run_seq(16'd5, 16'd0, 16'd0, 0);
        check_eq("t5_done_cycle", done_k, 8);
        check_eq("t5_wrapped", c_blk, 32'd3);
        check_eq("t5_pass", pass, 1);
        check_eq("t5_fail", fail, 0);
        step(1);

        // Reset asserted during the ctrl phase
        n_data = 16'd3;
        n_ctrl = 16'd4;
        n_inv  = 16'd0;
        start  = 1'b1;
        step(1);
        start = 1'b0;
        for (int k = 0; k < 20 && phase != 2'd1; k++) step(1);
        check_eq("t6_in_ctrl", phase, 1);
        step(1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", valid, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_pass", pass, 0);
        check_eq("t6_rst_fail", fail, 0);
        check_eq("t6_rst_phase", phase, 3);
        step(1);
        rst_n = 1'b1;
        step(3);
        run_seq(16'd1, 16'd1, 16'd1, 0);
        check_eq("t6_done_cycle", done_k, 6);
        check_eq("t6_ntx", ntx, 3);
        check_eq("t6_pass", pass, 1);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/baser_257b_traffic_sequencer.md
# baser_257b_traffic_sequencer

Programmable traffic controller for the 256b/257b checker path. It emits a fixed-order burst of 257-bit transcoded blocks (all-data, then control, then invalid) over a valid/ready handshake. It snapshots the checker's cumulative counters at start, waits for the checker pipeline to drain, then compares counter deltas against the programmed counts and reports pass/fail. It sits between the verification agent's configuration registers and the `BASER_257b_checker` input.

## Interface
- `DATA_WIDTH`, 64: width of one 64b sub-block.
- `TC_DATA_WIDTH`, 256: transcoded payload width (4 × DATA_WIDTH).
- `SH_WIDTH`, 1: transcoded header width.
- `TC_WIDTH`, 257: full transcoded block width.
- `DATA_CHAR_PATTERN`, 8'hAA: byte filling data positions.
- `CTRL_CHAR_PATTERN`, 8'h55: byte filling control positions.
- `CNT_WIDTH`, 16: width of the programmed block counts.
- `CHK_LATENCY`, 2: cycles from the last accepted block until checker counters are final.

Ports:
- `clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  start pulse; sampled only in IDLE.
- `i_n_data`  in  CNT_WIDTH  number of all-data blocks; sampled at start.
- `i_n_ctrl`  in  CNT_WIDTH  number of control blocks; sampled at start.
- `i_n_inv`  in  CNT_WIDTH  number of invalid blocks; sampled at start.
- `i_ready`  in  1  downstream accepts `o_tx_coded` this cycle.
- `i_chk_block_count`, `i_chk_data_count`, `i_chk_ctrl_count`, `i_chk_inv_count`  in  32 each  checker cumulative counters.
- `o_tx_coded`  out  TC_WIDTH  transcoded block.
- `o_valid`  out  1  `o_tx_coded` is valid.
- `o_busy`  out  1  high in every state except IDLE.
- `o_phase`  out  2  current traffic phase: 0 = data, 1 = ctrl, 2 = inv, 3 = none.
- `o_done`  out  1  one-cycle pulse when the result is final.
- `o_pass`, `o_fail`  out  1 each  result flags; held until the next accepted start.

## Operation
- FSM states: IDLE → DATA → CTRL → INV → DRAIN → CHECK → IDLE.
- **Start (IDLE, `i_start`=1):**
  - Latch the three counts.
  - Snapshot all four checker counters as baselines.
  - Clear `o_pass` and `o_fail`.
  - Go to the first phase with a non-zero count, or to DRAIN if all counts are zero.
- **Phase behaviour:**
  - `o_valid`=1 in DATA, CTRL and INV.
  - A transfer occurs when `o_valid` && `i_ready`. Each transfer decrements the phase's remaining count.
  - When the last block of a phase transfers, go to the next non-empty phase, or to DRAIN.
- **Block encodings:**
  - Data block: bit0=1; bits[256:1] = {32{DATA}}.
  - Control block: bit0=0; bits[4:1]=4'b1110; bits[64:5] = low 60 bits of {8{CTRL}}; bits[256:65] = {24{DATA}}.
  - Invalid block: bit0=0; bits[4:1]=4'b1111; bits[256:5] = DATA pattern.
- **DRAIN:** count CHK_LATENCY cycles with `o_valid`=0, then go to CHECK.
- **CHECK** (one cycle):
  - Compute each delta as current counter − baseline, mod 2^32.
  - Expected values:
    - block delta = n_data + n_ctrl + n_inv, zero-extended to 32 bits;
    - data delta = n_data;
    - ctrl delta = n_ctrl;
    - inv delta = n_inv.
  - All four equal → `o_pass`=1; otherwise `o_fail`=1.
  - Pulse `o_done`, return to IDLE.
- `i_start` outside IDLE is ignored.
- Checker counter wrap during a run is handled by the modular subtraction.

## Timing
- **Reset values:** state IDLE; `o_valid`=0, `o_busy`=0, `o_done`=0, `o_pass`=0, `o_fail`=0; `o_phase`=3; `o_tx_coded` = data-block encoding.
- **Start to first block:** `i_start` accepted at edge t → `o_valid`=1 from cycle t+1.
- **Backpressure:** while `o_valid` && !`i_ready`, `o_tx_coded` and `o_phase` hold stable.
- **Throughput:** one block per cycle when `i_ready` is held high.
- **Run length:** with N = n_data + n_ctrl + n_inv and `i_ready` always high, the last block is valid at cycle t+N. DRAIN occupies t+N+1 … t+N+CHK_LATENCY. `o_done` pulses at t+N+CHK_LATENCY+1, and `o_pass`/`o_fail` are valid from that cycle.
- **Phase change:** the phase advances in the same cycle as the last transfer; no bubble between phases.
- **Reset mid-run:** asynchronous return to reset values. Partial results are discarded and `o_valid` drops immediately.
- **Counter widths:** internal remaining counters are CNT_WIDTH; the expected-sum adder is CNT_WIDTH+2 bits.

## Structure
- Package `baser_257b_pkg` holds:
  - the width and pattern constants;
  - the state enum `seq_state_t`;
  - the phase encoding;
  - functions `mk_data_block()`, `mk_ctrl_block()`, `mk_inv_block()`.
- One sub-module, `baser_257b_count_compare`: baseline registers, modular subtraction and the four-way equality check, producing pass/fail.
- The FSM and counters stay in the top module.

## Test plan
- Reset, then start with 3/2/1 and `i_ready`=1, with a golden checker model → 6 valid cycles in order D,D,D,C,C,I; `o_done` at t+9; `o_pass`=1.
- Start with 0/0/0 → no valid cycles; `o_done` at t+CHK_LATENCY+1; `o_pass`=1.
- Start with 4/0/0, `i_ready` toggled 1,0,0,1,… → `o_tx_coded` stable during stalls; exactly 4 transfers; `o_pass`=1.
- Checker model miscounts one ctrl block as data (run 2/2/0) → `o_fail`=1, `o_pass`=0.
- Baseline counters set near 32'hFFFF_FFFE, run 5/0/0 → deltas wrap correctly; `o_pass`=1.
- Deassert `i_rst_n` mid-CTRL phase → `o_valid`, `o_busy` and results reset immediately; a new start runs cleanly.
